tone_synth: RTL and testbench
=============================

TONE_SYNTH -- requirements
Module: tone_synth

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent tone channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 12, width of pitch divider counter.
REQ-003 SHALL have parameter OCT_W, default 2, width of octave field; OCT_MAX = 2^OCT_W-1.
REQ-004 SHALL have port clk  input  1  single clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port note_in  input  NCH*(OCT_W+3)  per-channel note {octave[OCT_W-1:0], pitch[2:0]}, channel 0 in LSBs.
REQ-007 SHALL have port note_ld  input  NCH  per-channel one-cycle load strobe for note_in slice.
REQ-008 SHALL have port pending  output  NCH  high while a loaded note waits for its channel boundary.
REQ-009 SHALL have port speaker  output  NCH  per-channel square wave.
REQ-010 SHALL have port mix_out  output  1  sigma-delta mix of all channels.

Function
REQ-011 Pitch SHALL map to divider: 0 rest, 1..7 = 946,841,757,709,630,567,504 (C..B).
REQ-012 Each channel SHALL hold active note (act) and pending note (pnd) registers.
REQ-013 Prescale reload SHALL be ps = 2^(OCT_MAX-octave)-1; octave OCT_MAX is highest pitch.
REQ-014 Divider counter SHALL count down to 0, then reload divider; on each reload the prescale counter decrements, or, when 0, reloads ps and that cycle is a boundary.
REQ-015 Speaker SHALL toggle on every boundary of a non-rest active note; half-period = (div+1)*(ps+1) clocks.
REQ-016 Active rest note SHALL force speaker to 0 on the cycle after it becomes active and hold counters at 0.
REQ-017 note_ld with channel active-rest SHALL make the note active the next cycle (counters reload from it), pending stays 0.
REQ-018 note_ld with a playing channel SHALL store pnd, set pending next cycle; note becomes active at next boundary, counters reload from it, pending clears.
REQ-019 note_ld coinciding with a boundary cycle SHALL make the new note active at that boundary directly; pending stays 0.
REQ-020 note_ld while pending SHALL overwrite pnd (last load wins); no extra delay.
REQ-021 Note change SHALL never shorten or split a speaker half-period (glitch-free).
REQ-022 Mixer SHALL per cycle compute s = acc + popcount(speaker); if s >= NCH then mix_out<=1, acc<=s-NCH, else mix_out<=0, acc<=s.
REQ-023 acc width SHALL be clog2(2*NCH); mix_out density over any NCH-cycle window SHALL equal high-channel count within +/-1.
REQ-024 Channels SHALL be fully independent; simultaneous note_ld on all channels SHALL be legal.

Reset
REQ-025 rst_n low SHALL asynchronously clear speaker, mix_out, pending, acc, all counters, act and pnd (rest, octave 0).
REQ-026 Reset mid-note SHALL abandon the note; after release channel idles silent until next note_ld.
REQ-027 Reset release SHALL take effect on the first clk edge after rst_n rises; no output toggles before a note_ld.

Structure
REQ-028 Package tone_pkg SHALL hold pitch divider table, note field widths, and rest encoding constant.
REQ-029 Per-channel logic SHALL be sub-module tone_chan, instantiated NCH times by generate; mixer lives in top.
REQ-030 Implementation SHALL be 120-400 lines RTL, no latches, no inferred memories.

Verification
REQ-031 NCH=1, load {3,1} -> speaker toggles every 947 cycles; mix_out equals speaker delayed 1 cycle.
REQ-032 Load {2,7} -> half-period 1010 cycles; load {0,7} mid-period -> pending=1 until boundary, then half-period 4040, no short pulse.
REQ-033 Two note_ld on same channel before boundary ({3,2} then {3,6}) -> only 568-cycle note ever plays.
REQ-034 Load rest while playing -> speaker 0 one cycle after the boundary and held; next load {3,1} active next cycle.
REQ-035 NCH=2, both playing {3,1} and {3,5} -> mix_out high density over 10000 cycles within 1% of mean(speaker[0]+speaker[1])/2.
REQ-036 Assert rst_n low mid-half-period -> all outputs 0 asynchronously; after release outputs stay 0 for 5000 cycles without note_ld.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants for the tone synthesizer: note field layout, rest encoding
// and the pitch-to-divider lookup.
package tone_pkg;

    localparam int PITCH_W   = 3;
    localparam int DIV_TBL_W = 10;
    localparam logic [PITCH_W-1:0] REST_PITCH = '0;

    // Divider values for C..B at the top octave; pitch 0 is a rest.
    function automatic logic [DIV_TBL_W-1:0] pitch_div(input logic [PITCH_W-1:0] p);
        case (p)
            3'd1:    return 10'd946;
            3'd2:    return 10'd841;
            3'd3:    return 10'd757;
            3'd4:    return 10'd709;
            3'd5:    return 10'd630;
            3'd6:    return 10'd567;
            3'd7:    return 10'd504;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/tone_synth_if.sv
// Per-channel note/load/status bundle between the synth top and a tone channel.
interface tone_synth_if
    import tone_pkg::*;
#(
    parameter int OCT_W = 2
);
    logic [OCT_W+PITCH_W-1:0] note;
    logic                     ld;
    logic                     pending;
    logic                     speaker;

    modport master (output note, ld, input pending, speaker);
    modport slave  (input note, ld, output pending, speaker);
endinterface

// File: rtl/tone_chan.sv
// One square-wave tone channel: divider plus octave prescaler, with note changes
// deferred to half-period boundaries so no half-period is ever cut short.
module tone_chan
    import tone_pkg::*;
#(
    parameter int DIV_W = 12,
    parameter int OCT_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    tone_synth_if.slave  bus
);
    localparam int NOTE_W = OCT_W + PITCH_W;
    localparam int PS_W   = (1 << OCT_W) - 1;

    logic [NOTE_W-1:0] act_q, act_d;
    logic [NOTE_W-1:0] pnd_q, pnd_d;
    logic [NOTE_W-1:0] nxt;
    logic              pending_q, pending_d;
    logic              spk_q, spk_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic              boundary;

    function automatic logic is_rest(input logic [NOTE_W-1:0] n);
        return n[PITCH_W-1:0] == REST_PITCH;
    endfunction

    function automatic logic [DIV_W-1:0] div_of(input logic [NOTE_W-1:0] n);
        return DIV_W'(pitch_div(n[PITCH_W-1:0]));
    endfunction

    // Prescale reload 2^(OCT_MAX-oct)-1 is simply the all-ones word shifted by octave.
    function automatic logic [PS_W-1:0] ps_of(input logic [NOTE_W-1:0] n);
        logic [PS_W-1:0] ones;
        ones = '1;
        if (is_rest(n)) begin
            return '0;
        end
        return ones >> n[NOTE_W-1:PITCH_W];
    endfunction

    always_comb begin
        act_d     = act_q;
        pnd_d     = pnd_q;
        pending_d = pending_q;
        spk_d     = spk_q;
        div_d     = div_q;
        ps_d      = ps_q;
        nxt       = act_q;
        boundary  = !is_rest(act_q) && (div_q == '0) && (ps_q == '0);

        if (is_rest(act_q)) begin
            spk_d     = 1'b0;
            div_d     = '0;
            ps_d      = '0;
            pending_d = 1'b0;
            if (bus.ld) begin
                act_d = bus.note;
                div_d = div_of(bus.note);
                ps_d  = ps_of(bus.note);
            end
        end else if (boundary) begin
            // A load landing exactly on the boundary beats any older pending note.
            if (bus.ld) begin
                nxt = bus.note;
            end else if (pending_q) begin
                nxt = pnd_q;
            end
            act_d     = nxt;
            pending_d = 1'b0;
            div_d     = div_of(nxt);
            ps_d      = ps_of(nxt);
            spk_d     = is_rest(nxt) ? 1'b0 : ~spk_q;
        end else begin
            if (div_q == '0) begin
                div_d = div_of(act_q);
                ps_d  = ps_q - PS_W'(1);
            end else begin
                div_d = div_q - DIV_W'(1);
            end
            if (bus.ld) begin
                pnd_d     = bus.note;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q     <= '0;
            pnd_q     <= '0;
            pending_q <= 1'b0;
            spk_q     <= 1'b0;
            div_q     <= '0;
            ps_q      <= '0;
        end else begin
            act_q     <= act_d;
            pnd_q     <= pnd_d;
            pending_q <= pending_d;
            spk_q     <= spk_d;
            div_q     <= div_d;
            ps_q      <= ps_d;
        end
    end

    assign bus.pending = pending_q;
    assign bus.speaker = spk_q;

endmodule

// File: rtl/tone_synth.sv
// Multi-channel square-wave tone synthesizer with a first-order sigma-delta mix
// of all channel speakers onto a single output bit.
module tone_synth
    import tone_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DIV_W = 12,
    parameter int OCT_W = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NCH*(OCT_W+PITCH_W)-1:0] note_in,
    input  logic [NCH-1:0]                note_ld,
    output logic [NCH-1:0]                pending,
    output logic [NCH-1:0]                speaker,
    output logic                          mix_out
);
    localparam int NOTE_W = OCT_W + PITCH_W;
    localparam int ACC_W  = $clog2(2 * NCH);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        tone_synth_if #(.OCT_W(OCT_W)) ch_if ();

        assign ch_if.note = note_in[g*NOTE_W +: NOTE_W];
        assign ch_if.ld   = note_ld[g];
        assign pending[g] = ch_if.pending;
        assign speaker[g] = ch_if.speaker;

        tone_chan #(
            .DIV_W (DIV_W),
            .OCT_W (OCT_W)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ch_if.slave)
        );
    end

    logic [ACC_W-1:0] acc_q, acc_d, pop, sum;
    logic             mix_q, mix_d;

    // Accumulator residue stays below NCH, so acc + popcount never exceeds 2*NCH-1.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NCH; i++) begin
            pop = pop + ACC_W'(speaker[i]);
        end
        sum = acc_q + pop;
        if (sum >= ACC_W'(NCH)) begin
            mix_d = 1'b1;
            acc_d = sum - ACC_W'(NCH);
        end else begin
            mix_d = 1'b0;
            acc_d = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            mix_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            mix_q <= mix_d;
        end
    end

    assign mix_out = mix_q;

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: single-channel timing via a half-period scoreboard and a
// two-channel instance for the sigma-delta mix density.
module tb_tone_synth;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tone_synth_if #(.OCT_W(2)) bus1 ();
    logic       mix1;
    logic [9:0] note_in2;
    logic [1:0] note_ld2;
    logic [1:0] pending2;
    logic [1:0] speaker2;
    logic       mix2;

    tone_synth #(.NCH(1), .DIV_W(12), .OCT_W(2)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .note_in (bus1.note),
        .note_ld (bus1.ld),
        .pending (bus1.pending),
        .speaker (bus1.speaker),
        .mix_out (mix1)
    );

    tone_synth #(.NCH(2), .DIV_W(12), .OCT_W(2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .note_in (note_in2),
        .note_ld (note_ld2),
        .pending (pending2),
        .speaker (speaker2),
        .mix_out (mix2)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_evt = 0;
    int   exp_q[$];
    logic prev_spk = 1'b0;
    logic spk_last = 1'b0;
    logic rst_low_prev = 1'b1;

    typedef struct {
        logic [1:0] oct;
        logic [2:0] pitch;
        int         half;
    } vec_t;
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Each speaker edge pops the half-period expected when the note was loaded.
    always @(negedge clk) begin
        if (!rst_n || rst_low_prev) begin
            prev_spk = bus1.speaker;
        end else begin
            if (bus1.speaker !== prev_spk) begin
                if (exp_q.size() == 0) begin
                    check("spk_unexpected_toggle", cyc - last_evt, 0);
                end else begin
                    check("spk_half_period", cyc - last_evt, exp_q.pop_front());
                end
                last_evt = cyc;
                prev_spk = bus1.speaker;
            end
            check("mix1_delayed_speaker", int'(mix1), int'(spk_last));
        end
        spk_last     = bus1.speaker;
        rst_low_prev = !rst_n;
    end

    task automatic do_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_speaker", int'(bus1.speaker), 0);
        check("rst_pending", int'(bus1.pending), 0);
        check("rst_mix", int'(mix1), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic load1(input logic [1:0] oct, input logic [2:0] p, input bit ref_evt);
        @(negedge clk);
        bus1.note = {oct, p};
        bus1.ld   = 1'b1;
        @(posedge clk);
        #1;
        bus1.ld = 1'b0;
        if (ref_evt) last_evt = cyc;
    endtask

    task automatic wait_q_le(input int n, input int budget);
        int c = 0;
        while (exp_q.size() > n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("toggle_wait", exp_q.size(), n);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int sum;
        int mix_cnt;
        int d;

        bus1.note = '0;
        bus1.ld   = 1'b0;
        note_in2  = '0;
        note_ld2  = '0;

        vecs[0] = '{2'd3, 3'd1, 947};
        vecs[1] = '{2'd3, 3'd4, 710};
        vecs[2] = '{2'd3, 3'd7, 505};
        vecs[3] = '{2'd2, 3'd7, 1010};
        vecs[4] = '{2'd1, 3'd7, 2020};
        vecs[5] = '{2'd3, 3'd0, 0};

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("init_speaker", int'(bus1.speaker), 0);
        check("init_pending", int'(bus1.pending), 0);
        check("init_mix", int'(mix1), 0);
        check("init_speaker2", int'(speaker2), 0);

        // Single notes from idle: half-periods plus first toggle latency.
        foreach (vecs[i]) begin
            do_reset();
            load1(vecs[i].oct, vecs[i].pitch, 1'b1);
            check("idle_load_pending", int'(bus1.pending), 0);
            if (vecs[i].half != 0) begin
                repeat (3) exp_q.push_back(vecs[i].half);
                wait_q_le(0, 3 * vecs[i].half + 50);
            end else begin
                repeat (2000) @(negedge clk);
                check("rest_speaker", int'(bus1.speaker), 0);
            end
        end

        // Octave change mid-period waits for the boundary.
        do_reset();
        load1(2'd2, 3'd7, 1'b1);
        repeat (2) exp_q.push_back(1010);
        wait_q_le(1, 1100);
        repeat (300) @(negedge clk);
        load1(2'd0, 3'd7, 1'b0);
        check("mid_load_pending", int'(bus1.pending), 1);
        repeat (2) exp_q.push_back(4040);
        repeat (400) @(negedge clk);
        check("pending_held", int'(bus1.pending), 1);
        wait_q_le(2, 800);
        check("pending_cleared", int'(bus1.pending), 0);
        wait_q_le(0, 8200);

        // Two loads before the boundary: last one wins.
        do_reset();
        load1(2'd3, 3'd1, 1'b1);
        exp_q.push_back(947);
        repeat (100) @(negedge clk);
        load1(2'd3, 3'd2, 1'b0);
        repeat (100) @(negedge clk);
        load1(2'd3, 3'd6, 1'b0);
        check("overwrite_pending", int'(bus1.pending), 1);
        repeat (2) exp_q.push_back(568);
        wait_q_le(0, 2300);

        // Rest while playing, then a fresh note starts immediately.
        do_reset();
        load1(2'd3, 3'd7, 1'b1);
        repeat (2) exp_q.push_back(505);
        wait_q_le(1, 600);
        repeat (50) @(negedge clk);
        load1(2'd3, 3'd0, 1'b0);
        check("rest_pending", int'(bus1.pending), 1);
        wait_q_le(0, 600);
        @(negedge clk);
        check("rest_spk_low", int'(bus1.speaker), 0);
        check("rest_pending_clr", int'(bus1.pending), 0);
        repeat (2000) @(negedge clk);
        check("rest_spk_held", int'(bus1.speaker), 0);
        load1(2'd3, 3'd1, 1'b1);
        check("after_rest_pending", int'(bus1.pending), 0);
        exp_q.push_back(947);
        wait_q_le(0, 1000);

        // Load landing exactly on the boundary cycle.
        do_reset();
        load1(2'd3, 3'd7, 1'b1);
        t0 = last_evt;
        exp_q.push_back(505);
        while (cyc != t0 + 504) @(negedge clk);
        bus1.note = {2'd3, 3'd4};
        bus1.ld   = 1'b1;
        @(posedge clk);
        #1;
        bus1.ld = 1'b0;
        check("boundary_load_pending", int'(bus1.pending), 0);
        repeat (2) exp_q.push_back(710);
        wait_q_le(0, 2000);

        // Asynchronous reset mid half-period with a note pending.
        do_reset();
        load1(2'd3, 3'd1, 1'b1);
        repeat (2) exp_q.push_back(947);
        wait_q_le(1, 1000);
        repeat (200) @(negedge clk);
        load1(2'd3, 3'd5, 1'b0);
        check("pre_rst_pending", int'(bus1.pending), 1);
        check("pre_rst_speaker", int'(bus1.speaker), 1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_speaker", int'(bus1.speaker), 0);
        check("async_rst_pending", int'(bus1.pending), 0);
        check("async_rst_mix", int'(mix1), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5000) @(negedge clk);
        check("post_rst_speaker", int'(bus1.speaker), 0);
        check("post_rst_pending", int'(bus1.pending), 0);
        check("post_rst_mix", int'(mix1), 0);

        // Two-channel mix density.
        check("ch2_idle_speaker", int'(speaker2), 0);
        check("ch2_idle_mix", int'(mix2), 0);
        @(negedge clk);
        note_in2 = {2'd3, 3'd5, 2'd3, 3'd1};
        note_ld2 = 2'b11;
        @(posedge clk);
        #1;
        note_ld2 = 2'b00;
        check("ch2_idle_load_pending", int'(pending2), 0);
        repeat (10) @(negedge clk);
        note_in2 = {2'd3, 3'd3, 2'd3, 3'd7};
        note_ld2 = 2'b11;
        @(posedge clk);
        #1;
        note_ld2 = 2'b00;
        check("ch2_both_pending", int'(pending2), 3);
        sum     = 0;
        mix_cnt = 0;
        repeat (10000) begin
            @(negedge clk);
            sum     = sum + int'(speaker2[0]) + int'(speaker2[1]);
            mix_cnt = mix_cnt + int'(mix2);
        end
        check_range("ch2_speaker_activity", sum, 8800, 10200);
        d = 2 * mix_cnt - sum;
        if (d < 0) d = -d;
        check_range("ch2_mix_density", d, 0, sum / 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
